// File: rtl/pipelined_cla_addsub.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
// Each stage resolves one WIDTH/PIPE slice; unprocessed operands skew forward, finished sums deskew.
module pipelined_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int S  = WIDTH / PIPE;
    localparam int NG = S / GROUP;

    if ((WIDTH % (PIPE * GROUP)) != 0) begin : g_bad_cfg
        $error("pipelined_cla_addsub: WIDTH must be a multiple of PIPE*GROUP");
    end

    // Two-level lookahead over one slice: returns {carry_out, sum}. Every carry is a
    // sum-of-products of generates/propagates, so no carry ripples between groups.
    function automatic logic [S:0] cla_slice(input logic [S-1:0] x,
                                             input logic [S-1:0] y,
                                             input logic         ci);
        logic [S-1:0]  p, g, s;
        logic [NG-1:0] gp, gg;
        logic [NG:0]   gc;
        logic          acc, prod;
        p  = x ^ y;
        g  = x & y;
        s  = '0;
        gp = '0;
        gg = '0;
        gc = '0;
        for (int gi = 0; gi < NG; gi++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = GROUP - 1; j >= 0; j--) begin
                acc  = acc | (g[gi*GROUP+j] & prod);
                prod = prod & p[gi*GROUP+j];
            end
            gg[gi] = acc;
            gp[gi] = prod;
        end
        for (int gi = 0; gi <= NG; gi++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int m = gi - 1; m >= 0; m--) begin
                acc  = acc | (gg[m] & prod);
                prod = prod & gp[m];
            end
            gc[gi] = acc | (prod & ci);
        end
        for (int gi = 0; gi < NG; gi++) begin
            for (int j = 0; j < GROUP; j++) begin
                acc  = 1'b0;
                prod = 1'b1;
                for (int m = j - 1; m >= 0; m--) begin
                    acc  = acc | (g[gi*GROUP+m] & prod);
                    prod = prod & p[gi*GROUP+m];
                end
                s[gi*GROUP+j] = p[gi*GROUP+j] ^ (acc | (prod & gc[gi]));
            end
        end
        return {gc[NG], s};
    endfunction

    logic adv_s;
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    for (genvar k = 0; k < PIPE; k++) begin : g_stg
        localparam int LO  = k * S;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]  a_in_s, b_in_s;
        logic            sub_in_s, c_in_s, vld_in_s;
        logic [S:0]      res_s;
        logic [LO+S-1:0] sum_nxt_s;
        logic [LO+S-1:0] sum_r;
        logic            vld_r;

        if (k == 0) begin : g_head
            assign a_in_s    = a;
            assign b_in_s    = b;
            assign sub_in_s  = sub;
            assign c_in_s    = sub | cin;
            assign vld_in_s  = in_valid;
            assign sum_nxt_s = res_s[S-1:0];
        end else begin : g_body
            assign a_in_s    = g_stg[k-1].g_skew.a_r;
            assign b_in_s    = g_stg[k-1].g_skew.b_r;
            assign sub_in_s  = g_stg[k-1].g_skew.sub_r;
            assign c_in_s    = g_stg[k-1].g_skew.c_r;
            assign vld_in_s  = g_stg[k-1].vld_r;
            assign sum_nxt_s = {res_s[S-1:0], g_stg[k-1].sum_r};
        end

        assign res_s = cla_slice(a_in_s[S-1:0], b_in_s[S-1:0] ^ {S{sub_in_s}}, c_in_s);

        // Stage valid bit and accumulated (deskewed) sum bits; the last stage is the output.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_r <= 1'b0;
                sum_r <= '0;
            end else if (adv_s) begin
                vld_r <= vld_in_s;
                sum_r <= sum_nxt_s;
            end
        end

        if (k < PIPE - 1) begin : g_skew
            logic [REM-S-1:0] a_r, b_r;
            logic             sub_r, c_r;

            // Operand bits still to be added, the mode bit and the slice carry move on.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r   <= '0;
                    b_r   <= '0;
                    sub_r <= 1'b0;
                    c_r   <= 1'b0;
                end else if (adv_s) begin
                    a_r   <= a_in_s[REM-1:S];
                    b_r   <= b_in_s[REM-1:S];
                    sub_r <= sub_in_s;
                    c_r   <= res_s[S];
                end
            end
        end
    end

    logic             cout_r, ovf_r, zero_r, neg_r;
    logic [WIDTH-1:0] fin_sum_s;
    logic             fin_co_s, p_msb_s, c_msb_s;

    assign fin_sum_s = g_stg[PIPE-1].sum_nxt_s;
    assign fin_co_s  = g_stg[PIPE-1].res_s[S];
    assign p_msb_s   = g_stg[PIPE-1].a_in_s[S-1] ^ g_stg[PIPE-1].b_in_s[S-1] ^ g_stg[PIPE-1].sub_in_s;
    // The carry into the MSB is recovered from the MSB sum bit and its propagate.
    assign c_msb_s   = fin_sum_s[WIDTH-1] ^ p_msb_s;

    // Status flags registered alongside the final sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else if (adv_s) begin
            cout_r <= fin_co_s;
            ovf_r  <= c_msb_s ^ fin_co_s;
            zero_r <= ~|fin_sum_s;
            neg_r  <= fin_sum_s[WIDTH-1];
        end
    end

    assign out_valid = g_stg[PIPE-1].vld_r;
    assign sum       = g_stg[PIPE-1].sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;
    assign neg       = neg_r;

endmodule
